mmu_arb: RTL and testbench

Arbitrates the single MMU translation datapath between the instruction-fetch (IF) and load/store (LS) requesters. It accepts one translation at a time and sequences the MMU request/response exchange. It routes the physical address back to the owning requester, and enforces a response timeout and a flush/drain protocol. It sits in the CPU core between the fetch/LSU stages and the mmu block.

---
 rtl/mmu_arb_pkg.sv | 26 ++
 rtl/mmu_arb_sel.sv | 49 ++++
 rtl/mmu_arb.sv | 142 ++++++++++++++
 tb/tb_mmu_arb.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_arb_pkg.sv
// Shared definitions for the MMU translation arbiter: FSM state, owner
// encoding, default parameter values and a counter-width helper.
package mmu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam int DEF_VA_WIDTH     = 48;
    localparam int DEF_PA_WIDTH     = 56;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_TIMEOUT      = 64;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mmu_arb_sel.sv
// Requester selector: LS wins by default, IF wins when it is the only
// requester or once it has been denied STARVE_LIMIT arbitration rounds.
module mmu_arb_sel
    import mmu_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic flush,
    input  logic if_valid,
    input  logic ls_valid,
    output logic grant_if,
    output logic grant_ls
);

    localparam int            SW    = cnt_width(STARVE_LIMIT);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;
    logic          if_starved;

    assign if_starved = (starve_cnt >= LIMIT);

    // Grant decision; only meaningful while the arbiter can accept work.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (arb_en) begin
            if (if_valid && (!ls_valid || if_starved)) begin
                grant_if = 1'b1;
            end else if (ls_valid) begin
                grant_ls = 1'b1;
            end
        end
    end

    // Starvation count: a denial is an arbitration round that IF lost to LS,
    // so cycles spent waiting on the MMU do not age the IF request.
    always_ff @(posedge clk) begin
        if (rst || flush || !if_valid || grant_if) begin
            starve_cnt <= '0;
        end else if (grant_ls && !if_starved) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule

// File: rtl/mmu_arb.sv
// Arbiter for the shared MMU translation datapath between instruction fetch
// and load/store. One translation in flight; handles MMU response timeout
// and flush with drain of the outstanding MMU transaction.
module mmu_arb
    import mmu_arb_pkg::*;
#(
    parameter int VA_WIDTH     = DEF_VA_WIDTH,
    parameter int PA_WIDTH     = DEF_PA_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    input  logic [VA_WIDTH-1:0] if_req_va,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [PA_WIDTH-1:0] if_rsp_pa,
    output logic                if_rsp_fault,
    input  logic                ls_req_valid,
    input  logic [VA_WIDTH-1:0] ls_req_va,
    output logic                ls_req_ready,
    output logic                ls_rsp_valid,
    output logic [PA_WIDTH-1:0] ls_rsp_pa,
    output logic                ls_rsp_fault,
    input  logic                flush,
    output logic                mmu_va_valid,
    output logic [VA_WIDTH-1:0] mmu_va,
    input  logic                mmu_pa_valid,
    input  logic [PA_WIDTH-1:0] mmu_pa,
    output logic                busy
);

    localparam int            TW      = cnt_width(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    owner_t        owner;
    logic [TW-1:0] tmo_cnt;
    logic          arb_en;
    logic          grant_if;
    logic          grant_ls;
    logic          pa_honoured;

    assign arb_en = (state == ST_IDLE) && !flush && !rst;

    mmu_arb_sel #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_sel (
        .clk      (clk),
        .rst      (rst),
        .arb_en   (arb_en),
        .flush    (flush),
        .if_valid (if_req_valid),
        .ls_valid (ls_req_valid),
        .grant_if (grant_if),
        .grant_ls (grant_ls)
    );

    assign if_req_ready = grant_if;
    assign ls_req_ready = grant_ls;
    assign busy         = (state != ST_IDLE);

    // A response arriving in the issue cycle cannot belong to this request.
    assign pa_honoured = mmu_pa_valid && !mmu_va_valid;

    // Translation sequencer: accept, issue, wait/timeout, flush drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            owner        <= OWN_IF;
            tmo_cnt      <= '0;
            mmu_va       <= '0;
            mmu_va_valid <= 1'b0;
            if_rsp_valid <= 1'b0;
            if_rsp_pa    <= '0;
            if_rsp_fault <= 1'b0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_pa    <= '0;
            ls_rsp_fault <= 1'b0;
        end else begin
            mmu_va_valid <= 1'b0;
            if_rsp_valid <= 1'b0;
            if_rsp_fault <= 1'b0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_fault <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_if || grant_ls) begin
                        owner        <= grant_if ? OWN_IF : OWN_LS;
                        mmu_va       <= grant_if ? if_req_va : ls_req_va;
                        mmu_va_valid <= 1'b1;
                        tmo_cnt      <= '0;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (pa_honoured) begin
                        if (!flush) begin
                            if (owner == OWN_IF) begin
                                if_rsp_valid <= 1'b1;
                                if_rsp_pa    <= mmu_pa;
                            end else begin
                                ls_rsp_valid <= 1'b1;
                                ls_rsp_pa    <= mmu_pa;
                            end
                        end
                        state <= ST_IDLE;
                    end else if (flush) begin
                        // The MMU still owes a response; drain gets a fresh budget.
                        tmo_cnt <= '0;
                        state   <= ST_DRAIN;
                    end else if (tmo_cnt == TO_LAST) begin
                        if (owner == OWN_IF) begin
                            if_rsp_valid <= 1'b1;
                            if_rsp_pa    <= '0;
                            if_rsp_fault <= 1'b1;
                        end else begin
                            ls_rsp_valid <= 1'b1;
                            ls_rsp_pa    <= '0;
                            ls_rsp_fault <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (mmu_pa_valid || (tmo_cnt == TO_LAST)) begin
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_arb.sv
// Self-checking bench for mmu_arb: a transaction-level reference model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_mmu_arb;

    localparam int VA_W = 48;
    localparam int PA_W = 56;
    localparam int SLIM = 4;
    localparam int TMO  = 64;
    localparam logic [PA_W-1:0] PA_BASE = 56'hA0_0000_0000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req_valid;
    logic [VA_W-1:0] if_req_va;
    logic            if_req_ready;
    logic            if_rsp_valid;
    logic [PA_W-1:0] if_rsp_pa;
    logic            if_rsp_fault;
    logic            ls_req_valid;
    logic [VA_W-1:0] ls_req_va;
    logic            ls_req_ready;
    logic            ls_rsp_valid;
    logic [PA_W-1:0] ls_rsp_pa;
    logic            ls_rsp_fault;
    logic            flush;
    logic            mmu_va_valid;
    logic [VA_W-1:0] mmu_va;
    logic            mmu_pa_valid;
    logic [PA_W-1:0] mmu_pa;
    logic            busy;

    always #5 clk = ~clk;

    mmu_arb #(
        .VA_WIDTH     (VA_W),
        .PA_WIDTH     (PA_W),
        .STARVE_LIMIT (SLIM),
        .TIMEOUT      (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_va    (if_req_va),
        .if_req_ready (if_req_ready),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_pa    (if_rsp_pa),
        .if_rsp_fault (if_rsp_fault),
        .ls_req_valid (ls_req_valid),
        .ls_req_va    (ls_req_va),
        .ls_req_ready (ls_req_ready),
        .ls_rsp_valid (ls_rsp_valid),
        .ls_rsp_pa    (ls_rsp_pa),
        .ls_rsp_fault (ls_rsp_fault),
        .flush        (flush),
        .mmu_va_valid (mmu_va_valid),
        .mmu_va       (mmu_va),
        .mmu_pa_valid (mmu_pa_valid),
        .mmu_pa       (mmu_pa),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rsp_seen = 0;
    int grants[$];
    bit rec_grants = 1'b0;
    bit auto_mmu   = 1'b0;
    bit auto_pend  = 1'b0;

    // reference model: one outstanding transaction described by its age
    bit              m_active = 1'b0;
    bit              m_own_if = 1'b0;
    bit              m_drain  = 1'b0;
    int              m_age    = 0;
    int              m_dage   = 0;
    int              m_starve = 0;
    logic [VA_W-1:0] m_va     = '0;
    bit              m_if_v   = 1'b0;
    bit              m_ls_v   = 1'b0;
    bit              m_if_f   = 1'b0;
    bit              m_ls_f   = 1'b0;
    logic [PA_W-1:0] m_if_pa  = '0;
    logic [PA_W-1:0] m_ls_pa  = '0;
    bit              e_ifr;
    bit              e_lsr;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic model_deliver(input logic [PA_W-1:0] pa, input bit fault);
        if (m_own_if) begin
            m_if_v = 1'b1; m_if_pa = pa; m_if_f = fault;
        end else begin
            m_ls_v = 1'b1; m_ls_pa = pa; m_ls_f = fault;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // MMU stand-in: answers one cycle after each issue pulse while enabled
    initial forever begin
        @(posedge clk);
        #2;
        if (auto_mmu) begin
            mmu_pa_valid = auto_pend;
            mmu_pa       = PA_BASE + PA_W'(cyc);
        end
        auto_pend = mmu_va_valid;
    end

    // every-cycle compare against the model, then advance the model
    initial forever begin
        @(negedge clk);
        e_ifr = 1'b0;
        e_lsr = 1'b0;
        if (!rst && !m_active && !flush) begin
            if (if_req_valid && (!ls_req_valid || m_starve >= SLIM)) e_ifr = 1'b1;
            else if (ls_req_valid) e_lsr = 1'b1;
        end
        chk("if_req_ready", 64'(if_req_ready), 64'(e_ifr));
        chk("ls_req_ready", 64'(ls_req_ready), 64'(e_lsr));
        chk("busy", 64'(busy), 64'(m_active));
        chk("mmu_va_valid", 64'(mmu_va_valid), 64'(m_active && !m_drain && m_age == 1));
        if (m_active) chk("mmu_va", 64'(mmu_va), 64'(m_va));
        chk("if_rsp_valid", 64'(if_rsp_valid), 64'(m_if_v));
        chk("ls_rsp_valid", 64'(ls_rsp_valid), 64'(m_ls_v));
        if (m_if_v) begin
            chk("if_rsp_pa", 64'(if_rsp_pa), 64'(m_if_pa));
            chk("if_rsp_fault", 64'(if_rsp_fault), 64'(m_if_f));
        end
        if (m_ls_v) begin
            chk("ls_rsp_pa", 64'(ls_rsp_pa), 64'(m_ls_pa));
            chk("ls_rsp_fault", 64'(ls_rsp_fault), 64'(m_ls_f));
        end
        chk("rsp_exclusive", 64'(if_rsp_valid && ls_rsp_valid), 64'(0));
        if (if_rsp_valid || ls_rsp_valid) rsp_seen++;
        if (rec_grants && ls_req_ready) grants.push_back(0);
        if (rec_grants && if_req_ready) grants.push_back(1);

        m_if_v = 1'b0;
        m_ls_v = 1'b0;
        if (rst) begin
            m_active = 1'b0; m_drain = 1'b0; m_starve = 0; m_va = '0;
        end else begin
            if (flush || !if_req_valid || e_ifr) m_starve = 0;
            else if (e_lsr && m_starve < SLIM) m_starve++;
            if (!m_active) begin
                if (e_ifr || e_lsr) begin
                    m_active = 1'b1; m_own_if = e_ifr; m_drain = 1'b0; m_age = 1;
                    m_va = e_ifr ? if_req_va : ls_req_va;
                end
            end else if (!m_drain) begin
                if (mmu_pa_valid && m_age >= 2) begin
                    m_active = 1'b0;
                    if (!flush) model_deliver(mmu_pa, 1'b0);
                end else if (flush) begin
                    m_drain = 1'b1; m_dage = 1;
                end else if (m_age == TMO) begin
                    m_active = 1'b0;
                    model_deliver('0, 1'b1);
                end else begin
                    m_age++;
                end
            end else begin
                if (mmu_pa_valid || m_dage == TMO) m_active = 1'b0;
                else m_dage++;
            end
        end
    end

    // with the MMU stand-in running, wait for the arbiter to go idle
    task automatic settle_idle(input string nm);
        for (int i = 0; i < 20; i++) begin
            nxt();
            @(negedge clk);
            if (!busy) break;
        end
        chk(nm, 64'(busy), 64'(0));
        nxt();
        auto_mmu     = 1'b0;
        mmu_pa_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t_issue;
        int base;
        bit got;
        rst = 1'b1; flush = 1'b0;
        if_req_valid = 1'b0; if_req_va = '0;
        ls_req_valid = 1'b0; ls_req_va = '0;
        mmu_pa_valid = 1'b0; mmu_pa = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_mmu_va_valid", 64'(mmu_va_valid), 64'(0));
        chk("rst_mmu_va", 64'(mmu_va), 64'(0));
        chk("rst_if_rsp", 64'(if_rsp_valid), 64'(0));
        chk("rst_ls_rsp", 64'(ls_rsp_valid), 64'(0));
        chk("rst_if_pa", 64'(if_rsp_pa), 64'(0));

        // single LS translation, MMU answers one cycle after issue
        nxt(); ls_req_valid = 1'b1; ls_req_va = 48'h0000_1234_5000;
        @(negedge clk); chk("t1_ls_ready", 64'(ls_req_ready), 64'(1));
        nxt(); ls_req_valid = 1'b0;
        @(negedge clk);
        chk("t1_issue", 64'(mmu_va_valid), 64'(1));
        chk("t1_va", 64'(mmu_va), 64'h0000_1234_5000);
        nxt(); mmu_pa_valid = 1'b1; mmu_pa = 56'h00_0000_8765_4000;
        @(negedge clk); chk("t1_no_early_rsp", 64'(ls_rsp_valid), 64'(0));
        nxt(); mmu_pa_valid = 1'b0;
        @(negedge clk);
        chk("t1_rsp_valid", 64'(ls_rsp_valid), 64'(1));
        chk("t1_rsp_pa", 64'(ls_rsp_pa), 64'h00_0000_8765_4000);
        chk("t1_rsp_fault", 64'(ls_rsp_fault), 64'(0));
        chk("t1_if_quiet", 64'(if_rsp_valid), 64'(0));

        // both requesters held: four LS grants then one IF grant, repeating
        nxt();
        grants.delete(); rec_grants = 1'b1; auto_mmu = 1'b1;
        if_req_valid = 1'b1; if_req_va = 48'h0000_0040_0000;
        ls_req_valid = 1'b1; ls_req_va = 48'h0000_0080_0000;
        repeat (45) nxt();
        if_req_valid = 1'b0; ls_req_valid = 1'b0; rec_grants = 1'b0;
        settle_idle("t2_settle");
        chk("t2_ngrants", 64'(grants.size() >= 10), 64'(1));
        for (int i = 0; i < 10 && i < grants.size(); i++)
            chk($sformatf("t2_grant%0d_is_if", i), 64'(grants[i]), 64'((i % 5) == 4));

        // no MMU response: fault exactly TIMEOUT cycles after issue
        nxt(); if_req_valid = 1'b1; if_req_va = 48'h7FFF_0000_1000;
        @(negedge clk); chk("t3_if_ready", 64'(if_req_ready), 64'(1));
        nxt(); if_req_valid = 1'b0;
        @(negedge clk); chk("t3_issue", 64'(mmu_va_valid), 64'(1));
        t_issue = cyc;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            nxt();
            @(negedge clk);
            if (if_rsp_valid) begin got = 1'b1; break; end
        end
        chk("t3_rsp_seen", 64'(got), 64'(1));
        chk("t3_gap", 64'(cyc - t_issue), 64'(TMO));
        chk("t3_fault", 64'(if_rsp_fault), 64'(1));
        chk("t3_pa_zero", 64'(if_rsp_pa), 64'(0));
        nxt(); mmu_pa_valid = 1'b1; mmu_pa = 56'h00_0000_DEAD_0000; base = rsp_seen;
        nxt(); mmu_pa_valid = 1'b0;
        repeat (3) nxt();
        @(negedge clk);
        chk("t3_late_ignored", 64'(rsp_seen - base), 64'(0));
        chk("t3_idle", 64'(busy), 64'(0));

        // flush in second WAIT cycle, MMU answers five cycles later
        nxt(); ls_req_valid = 1'b1; ls_req_va = 48'h0000_ABCD_0000;
        @(negedge clk); chk("t4_ls_ready", 64'(ls_req_ready), 64'(1));
        nxt(); ls_req_valid = 1'b0;
        nxt(); flush = 1'b1; base = rsp_seen;
        nxt(); flush = 1'b0;
        repeat (3) nxt();
        nxt(); mmu_pa_valid = 1'b1; mmu_pa = 56'h11_2222_3333_4000;
        @(negedge clk); chk("t4_busy_drain", 64'(busy), 64'(1));
        nxt(); mmu_pa_valid = 1'b0; if_req_valid = 1'b1; if_req_va = 48'h0000_0000_2000;
        @(negedge clk);
        chk("t4_idle", 64'(busy), 64'(0));
        chk("t4_regrant", 64'(if_req_ready), 64'(1));
        chk("t4_no_rsp", 64'(rsp_seen - base), 64'(0));
        nxt(); if_req_valid = 1'b0; auto_mmu = 1'b1;
        settle_idle("t4_settle");

        // reset in WAIT clears everything; a stray response is ignored
        nxt(); ls_req_valid = 1'b1; ls_req_va = 48'h0000_5555_0000;
        nxt(); ls_req_valid = 1'b0;
        nxt(); rst = 1'b1;
        nxt(); rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", 64'(busy), 64'(0));
        chk("t5_mmu_va_valid", 64'(mmu_va_valid), 64'(0));
        chk("t5_mmu_va", 64'(mmu_va), 64'(0));
        chk("t5_ls_pa", 64'(ls_rsp_pa), 64'(0));
        chk("t5_if_pa", 64'(if_rsp_pa), 64'(0));
        nxt(); mmu_pa_valid = 1'b1; mmu_pa = 56'h00_0000_7777_0000; base = rsp_seen;
        nxt(); mmu_pa_valid = 1'b0;
        repeat (2) nxt();
        @(negedge clk);
        chk("t5_no_rsp", 64'(rsp_seen - base), 64'(0));
        chk("t5_idle", 64'(busy), 64'(0));

        // flush held in IDLE blocks both requesters
        nxt(); flush = 1'b1;
        if_req_valid = 1'b1; if_req_va = 48'h0000_0001_0000;
        ls_req_valid = 1'b1; ls_req_va = 48'h0000_0002_0000;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) nxt();
            @(negedge clk);
            chk("t6_if_blocked", 64'(if_req_ready), 64'(0));
            chk("t6_ls_blocked", 64'(ls_req_ready), 64'(0));
        end
        nxt(); flush = 1'b0;
        @(negedge clk);
        chk("t6_ls_grant", 64'(ls_req_ready), 64'(1));
        chk("t6_if_denied", 64'(if_req_ready), 64'(0));
        nxt(); if_req_valid = 1'b0; ls_req_valid = 1'b0; auto_mmu = 1'b1;
        settle_idle("t6_settle");

        // flush together with an honoured response suppresses it
        nxt(); ls_req_valid = 1'b1; ls_req_va = 48'h0000_0003_0000;
        nxt(); ls_req_valid = 1'b0;
        nxt(); mmu_pa_valid = 1'b1; mmu_pa = 56'h00_0000_4444_0000; flush = 1'b1; base = rsp_seen;
        nxt(); mmu_pa_valid = 1'b0; flush = 1'b0;
        @(negedge clk); chk("t7_idle", 64'(busy), 64'(0));
        nxt();
        @(negedge clk); chk("t7_suppressed", 64'(rsp_seen - base), 64'(0));

        // a registered response still goes out under flush
        nxt(); if_req_valid = 1'b1; if_req_va = 48'h0000_0004_0000;
        nxt(); if_req_valid = 1'b0;
        nxt(); mmu_pa_valid = 1'b1; mmu_pa = 56'h00_0012_3456_7000;
        nxt(); mmu_pa_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("t8_rsp_under_flush", 64'(if_rsp_valid), 64'(1));
        chk("t8_pa", 64'(if_rsp_pa), 64'h00_0012_3456_7000);
        nxt(); flush = 1'b0;
        repeat (2) nxt();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
